serial_io_controller: RTL and testbench



---
 rtl/serial_io_controller_pkg.sv | 22 ++
 rtl/serial_io_controller_byte_fifo.sv | 54 +++++
 rtl/serial_io_controller.sv | 130 +++++++++++++
 tb/tb_serial_io_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_io_controller_pkg.sv
// Shared definitions for the memory-mapped serial port controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serial_io_controller_pkg;

  // Register offsets relative to MMIO_BASE
  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  // STATUS register bit positions
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_SPACE = 1;
  localparam int ST_TX_DROP  = 2;

  // Transmit sequencer states
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/serial_io_controller_byte_fifo.sv
// Byte-wide circular FIFO with power-of-two depth.
// Latency: a push at edge N is visible at head_o in the cycle after edge N.
// Backpressure: push while full is ignored (even with a same-cycle pop); pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: empty_o gates every consumer of head_o
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/serial_io_controller.sv
// Memory-mapped DATA/STATUS front end sharing a byte serial port through RX/TX FIFOs.
// Latency: RX byte readable the cycle after acceptance; TX strobe earliest the cycle after edge N+1 for a write at edge N.
// Backpressure: serial_rden_out drops when RX is full; TX writes into a full FIFO are dropped and flagged in tx_drop.
module serial_io_controller
  import serial_io_controller_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  input  logic [7:0]  serial_in,
  input  logic        serial_valid_in,
  input  logic        serial_ready_in,
  output logic        serial_rden_out,
  output logic [7:0]  serial_out,
  output logic        serial_wren_out
);

  logic       data_sel, status_sel;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       tx_drop_q, tx_drop_d;
  logic [7:0] serial_out_q, serial_out_d;
  logic       wren_q, wren_d;
  tx_state_e  state_q, state_d;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign data_sel   = (addr == MMIO_BASE + DATA_OFS);
  assign status_sel = (addr == MMIO_BASE + STATUS_OFS);

  // Holding rden low in reset keeps the source from handing over bytes that would be lost
  assign serial_rden_out = reset & ~rx_full;
  assign rx_push         = serial_valid_in & serial_rden_out;
  assign rx_pop          = mem_read & data_sel & ~rx_empty;
  assign tx_push         = mem_write & data_sel;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (serial_in),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (wdata[7:0]),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  // Load data mux; an empty DATA read returns zero rather than stale storage
  always_comb begin
    rdata = '0;
    if (mem_read && data_sel && !rx_empty) begin
      rdata = {24'b0, rx_head};
    end else if (mem_read && status_sel) begin
      rdata[ST_RX_AVAIL] = ~rx_empty;
      rdata[ST_TX_SPACE] = ~tx_full;
      rdata[ST_TX_DROP]  = tx_drop_q;
    end
  end

  // Sticky drop flag: a drop in the same cycle as a STATUS read wins
  always_comb begin
    tx_drop_d = tx_drop_q;
    if (tx_push && tx_full) begin
      tx_drop_d = 1'b1;
    end else if (mem_read && status_sel) begin
      tx_drop_d = 1'b0;
    end
  end

  // TX sequencer: strobe one cycle, then two quiet cycles before the next byte
  always_comb begin
    state_d      = state_q;
    serial_out_d = serial_out_q;
    wren_d       = 1'b0;
    tx_pop       = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && serial_ready_in) begin
          tx_pop       = 1'b1;
          serial_out_d = tx_head;
          wren_d       = 1'b1;
          state_d      = TX_SEND;
        end
      end
      TX_SEND: state_d = TX_GAP;
      TX_GAP:  state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  // Registered state; reset cancels an in-flight strobe immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= TX_IDLE;
      serial_out_q <= 8'h00;
      wren_q       <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      serial_out_q <= serial_out_d;
      wren_q       <= wren_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  assign serial_out      = serial_out_q;
  assign serial_wren_out = wren_q;

endmodule

// File: tb/tb_serial_io_controller.sv
// Self-checking bench: directed scenarios followed by random traffic, all against a queue-based reference model.
// Latency: n/a.
// Backpressure: the source holds a byte until the model says the controller accepted it.
module tb_serial_io_controller;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] DATA_A = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  serial_in = '0;
  logic        serial_valid_in = 1'b0;
  logic        serial_ready_in = 1'b0;
  logic        serial_rden_out;
  logic [7:0]  serial_out;
  logic        serial_wren_out;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as queues, sender cooldown in cycles
  byte unsigned rx_q[$];
  byte unsigned tx_q[$];
  logic         m_drop;
  int           m_cd;
  logic         m_wren;
  logic [7:0]   m_out;

  always #5 clock = ~clock;

  serial_io_controller #(
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .addr            (addr),
    .wdata           (wdata),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .rdata           (rdata),
    .serial_in       (serial_in),
    .serial_valid_in (serial_valid_in),
    .serial_ready_in (serial_ready_in),
    .serial_rden_out (serial_rden_out),
    .serial_out      (serial_out),
    .serial_wren_out (serial_wren_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (rx_q.size() > 0);
    s[1] = (tx_q.size() < DEPTH);
    s[2] = m_drop;
    return s;
  endfunction

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_drop = 1'b0;
    m_cd   = 0;
    m_wren = 1'b0;
    m_out  = 8'h00;
  endtask

  // One clock: drive, check mid-cycle, advance model at the edge
  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] wd, input logic rd,
                      input logic sv, input logic [7:0] sin, input logic sr);
    logic [31:0] er;
    int          rsz, tsz;
    logic        dsel, ssel, pop_tx;
    addr            = a;
    wdata           = $urandom();
    wdata[7:0]      = wd;
    mem_write       = wr;
    mem_read        = rd;
    serial_valid_in = sv;
    serial_in       = sin;
    serial_ready_in = sr;
    #2;
    dsel = (a == DATA_A);
    ssel = (a == STAT_A);
    er   = '0;
    if (rd && dsel && rx_q.size() > 0) er = {24'b0, rx_q[0]};
    else if (rd && ssel) er = exp_status();
    check("rdata", rdata, er);
    check("rden", {31'b0, serial_rden_out}, {31'b0, rx_q.size() < DEPTH});
    check("wren", {31'b0, serial_wren_out}, {31'b0, m_wren});
    check("serial_out", {24'b0, serial_out}, {24'b0, m_out});
    @(posedge clock);
    rsz = rx_q.size();
    tsz = tx_q.size();
    if (rd && dsel && rsz > 0) void'(rx_q.pop_front());
    if (sv && rsz < DEPTH) rx_q.push_back(sin);
    pop_tx = (m_cd == 0) && (tsz > 0) && sr;
    m_wren = pop_tx;
    if (pop_tx) begin
      m_out = tx_q.pop_front();
      m_cd  = 2;
    end else if (m_cd > 0) begin
      m_cd--;
    end
    if (wr && dsel) begin
      if (tsz == DEPTH) m_drop = 1'b1;
      else tx_q.push_back(wd);
    end else if (rd && ssel) begin
      m_drop = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic sr);
    step(32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, sr);
  endtask

  initial begin
    int          k;
    logic        acc;
    logic [31:0] ra;
    logic [1:0]  sel;

    // Reset state
    model_reset();
    #3;
    check("rst_rden", {31'b0, serial_rden_out}, 32'h0);
    check("rst_wren", {31'b0, serial_wren_out}, 32'h0);
    check("rst_sout", {24'b0, serial_out}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(STAT_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

    // Two received bytes read back in order
    step(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0);
    step(32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b0);
    step(DATA_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(DATA_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(STAT_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(DATA_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

    // RX fill: source holds the fifth byte until space frees up
    k = 0;
    for (int i = 0; i < 7; i++) begin
      acc = (rx_q.size() < DEPTH);
      step((i == 5) ? DATA_A : 32'h0, 1'b0, 8'h00, (i == 5), (k < 5), 8'h60 + 8'(k), 1'b0);
      if (acc && k < 5) k++;
    end
    for (int i = 0; i < 5; i++) step(DATA_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);

    // Two transmitted bytes, strobe width and gap follow the model
    step(DATA_A, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1);
    step(DATA_A, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // TX overflow sets the sticky drop flag
    for (int i = 1; i <= 5; i++) step(DATA_A, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    step(STAT_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    step(STAT_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) idle(1'b1);

    // Reset asserted while a strobe is in flight
    for (int i = 0; i < 3; i++) step(DATA_A, 1'b1, 8'h31 + 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1'b1);
    check("send_wren", {31'b0, serial_wren_out}, {31'b0, m_wren});
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_wren", {31'b0, serial_wren_out}, 32'h0);
    check("mid_rst_rden", {31'b0, serial_rden_out}, 32'h0);
    check("mid_rst_sout", {24'b0, serial_out}, 32'h0);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) idle(1'b1);
    step(STAT_A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd0, 2'd1: ra = DATA_A;
        2'd2:       ra = STAT_A;
        default:    ra = $urandom();
      endcase
      step(ra, ($urandom_range(0, 2) == 0), 8'($urandom()), 1'($urandom()),
           1'($urandom()), 8'($urandom()), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
